conv1x1_stream_sequencer: RTL and testbench
===========================================

Name: conv1x1_stream_sequencer

Overview:
- Front-end sequencer for the pointwise (1x1) convolution path of conv_top; sits between the pixel input stream and the MAC array.
- Counts ci-groups, columns and rows of an incoming NHWC pixel stream and generates the matching weight-buffer read address and first/last-channel flags for each accepted word.
- Successor to the fixed stride-1 1x1 bypass: parametrised lane count, optional stride-2 decimation in the 1x1 path, valid/ready backpressure, last-beat checking and a done pulse.

Parameters:
- LANES, 8, int8 channels per input word; pixel word width is 8*LANES.
- WT_ADDR_WIDTH, 12, weight-buffer address width.
- GRP_W, 10, width of ci-group count/index.
- DIM_W, 16, width of image width/height config and counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- go  in  1  start pulse; sampled in IDLE only.
- cfg_ci_groups  in  GRP_W  input channels / LANES; must be >=1.
- cfg_img_width  in  DIM_W  pixels per row; must be >=1.
- cfg_img_height  in  DIM_W  rows; must be >=1.
- cfg_stride_2  in  1  keep only even row / even column pixels.
- cfg_wt_base_addr  in  WT_ADDR_WIDTH  weight address of ci-group 0.
- pixel_in  in  8*LANES  input word.
- pixel_in_valid  in  1  input valid.
- pixel_in_last  in  1  marks final word of the image.
- pixel_in_ready  out  1  input ready.
- mac_pixel  out  8*LANES  registered pixel word to the MAC.
- mac_wt_addr  out  WT_ADDR_WIDTH  cfg_wt_base_addr + group index, modulo 2^WT_ADDR_WIDTH.
- mac_first_channel  out  1  group index == 0.
- mac_last_channel  out  1  group index == cfg_ci_groups-1.
- mac_valid  out  1  output valid.
- mac_ready  in  1  MAC accepts the word.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.
- err_last  out  1  sticky pixel_in_last mismatch flag.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all outputs 0: pixel_in_ready, mac_valid, mac_pixel, mac_wt_addr, both flags, busy, done, err_last. All counters 0. Reset mid-image abandons the image; no done is produced.
- States:
  - IDLE: on go, latch all cfg_* inputs, clear the counters and err_last, go to RUN. go while busy is ignored.
  - RUN: transfer occurs when pixel_in_valid && pixel_in_ready.
  - DRAIN: pixel_in_ready=0; wait until the output register is empty or accepted.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Counters per transfer:
  - grp increments and wraps at cfg_ci_groups-1.
  - col advances when grp wraps and wraps at cfg_img_width-1.
  - row advances when col wraps.
- Drop rule: when cfg_stride_2=1 and (row[0] | col[0]), the word is dropped. A dropped word is still consumed and counted but never reaches the output.
- pixel_in_ready = RUN && (drop_current || !mac_valid || mac_ready). Combinational from state, counters and mac_ready only; it does not depend on pixel_in_valid.
- Kept word: loaded into the output register with mac_valid=1 on the next cycle (latency 1). mac_valid holds and the outputs are stable until mac_ready=1. Back-to-back throughput is one word per cycle.
- Final word: the word with grp, col and row all at their maximum. After it transfers, go to DRAIN, then DONE once the output register is empty, i.e. mac_valid=0 or mac_ready=1 in that cycle.
- pixel_in_last checks:
  - Asserted on a non-final word: set err_last and treat that word as the final word (early termination).
  - Absent on the final word: set err_last; the counter-based end still applies.
- Odd width or height with stride 2 keeps ceil(W/2) x ceil(H/2) pixels.
- Simultaneous output accept and new load: permitted in the same cycle (register overwritten).

Optional Feature:
- Macro: CONV1X1_PERF_CNT_EN.
- When defined, adds output ports:
  - perf_stall_cycles (32 bits): counts RUN/DRAIN cycles with mac_valid && !mac_ready.
  - perf_dropped_words (32 bits): counts stride-2 dropped transfers.
- Both counters clear on go and saturate at all-ones.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- 4x4 image, CI_GROUPS=2, stride 1, base 0, mac_ready=1, continuous valid -> 32 mac_valid beats with addresses 0,1,0,1...; last_channel on odd beats; done exactly 2 cycles after the final transfer (DRAIN, then DONE); err_last=0.
- Same image with stride 2 -> 8 beats, carrying pixels (0,0),(0,2),(2,0),(2,2) x 2 groups in order; all 32 words consumed; pixel_in_ready stays high; perf_dropped_words=24 when the macro is enabled.
- Base address 100, CI_GROUPS=3, 2x2 image, mac_ready toggling 1010... -> 12 beats, addresses 100,101,102 repeating; outputs stable while stalled; no words lost or duplicated; perf_stall_cycles equals the count of stalled cycles.
- pixel_in_last asserted on word 10 of 32 -> err_last=1; done follows after the drain; no further words accepted. A second run has last absent on word 31 -> err_last=1 and done still produced.
- Reset asserted at word 15 of 32 -> all outputs 0 immediately; no done. A subsequent go with a new config completes normally.
- go pulsed while busy -> ignored; config changed mid-run has no effect on addresses.

Source files
------------

// File: rtl/conv1x1_stream_sequencer.sv
// conv1x1_stream_sequencer: front end of the 1x1 convolution path.
// Walks an NHWC pixel stream (ci-group fastest, then column, then row) and
// tags each kept word with its weight-buffer address and first/last-channel
// flags before handing it to the MAC through a single output register.
// Optional build macro: CONV1X1_PERF_CNT_EN adds the stall/drop counters.
module conv1x1_stream_sequencer #(
    parameter int LANES         = 8,
    parameter int WT_ADDR_WIDTH = 12,
    parameter int GRP_W         = 10,
    parameter int DIM_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     go,
    input  logic [GRP_W-1:0]         cfg_ci_groups,
    input  logic [DIM_W-1:0]         cfg_img_width,
    input  logic [DIM_W-1:0]         cfg_img_height,
    input  logic                     cfg_stride_2,
    input  logic [WT_ADDR_WIDTH-1:0] cfg_wt_base_addr,
    input  logic [8*LANES-1:0]       pixel_in,
    input  logic                     pixel_in_valid,
    input  logic                     pixel_in_last,
    output logic                     pixel_in_ready,
    output logic [8*LANES-1:0]       mac_pixel,
    output logic [WT_ADDR_WIDTH-1:0] mac_wt_addr,
    output logic                     mac_first_channel,
    output logic                     mac_last_channel,
    output logic                     mac_valid,
    input  logic                     mac_ready,
`ifdef CONV1X1_PERF_CNT_EN
    output logic [31:0]              perf_stall_cycles,
    output logic [31:0]              perf_dropped_words,
`endif
    output logic                     busy,
    output logic                     done,
    output logic                     err_last
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [GRP_W-1:0] GRP_ONE = 1;
    localparam logic [DIM_W-1:0] DIM_ONE = 1;

    state_t                     state;
    logic [GRP_W-1:0]           grp_q;
    logic [DIM_W-1:0]           col_q;
    logic [DIM_W-1:0]           row_q;
    logic [GRP_W-1:0]           groups_q;
    logic [DIM_W-1:0]           width_q;
    logic [DIM_W-1:0]           height_q;
    logic                       stride_2_q;
    logic [WT_ADDR_WIDTH-1:0]   base_q;

    logic grp_max, col_max, row_max, is_final, drop_cur, xfer;
    logic [WT_ADDR_WIDTH-1:0] wt_addr_nxt;

    // Position decode for the word currently on the input.
    assign grp_max     = (grp_q == groups_q - GRP_ONE);
    assign col_max     = (col_q == width_q - DIM_ONE);
    assign row_max     = (row_q == height_q - DIM_ONE);
    assign is_final    = grp_max && col_max && row_max;
    // Odd row or odd column is decimated away in stride-2 mode.
    assign drop_cur    = stride_2_q && (row_q[0] || col_q[0]);
    // A dropped word never needs the output register, so it is never stalled.
    assign pixel_in_ready = (state == S_RUN) && (drop_cur || !mac_valid || mac_ready);
    assign xfer        = pixel_in_valid && pixel_in_ready;
    assign wt_addr_nxt = base_q + WT_ADDR_WIDTH'(grp_q);

    // Sequencer FSM, position counters and the registered MAC-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            grp_q             <= '0;
            col_q             <= '0;
            row_q             <= '0;
            groups_q          <= '0;
            width_q           <= '0;
            height_q          <= '0;
            stride_2_q        <= 1'b0;
            base_q            <= '0;
            mac_pixel         <= '0;
            mac_wt_addr       <= '0;
            mac_first_channel <= 1'b0;
            mac_last_channel  <= 1'b0;
            mac_valid         <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err_last          <= 1'b0;
        end else begin
            done <= 1'b0;

            // Output register: a kept word overwrites it even if it is being
            // accepted this same cycle; otherwise acceptance empties it.
            if (xfer && !drop_cur) begin
                mac_valid         <= 1'b1;
                mac_pixel         <= pixel_in;
                mac_wt_addr       <= wt_addr_nxt;
                mac_first_channel <= (grp_q == '0);
                mac_last_channel  <= grp_max;
            end else if (mac_ready) begin
                mac_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (go) begin
                        groups_q   <= cfg_ci_groups;
                        width_q    <= cfg_img_width;
                        height_q   <= cfg_img_height;
                        stride_2_q <= cfg_stride_2;
                        base_q     <= cfg_wt_base_addr;
                        grp_q      <= '0;
                        col_q      <= '0;
                        row_q      <= '0;
                        err_last   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        if (grp_max) begin
                            grp_q <= '0;
                            if (col_max) begin
                                col_q <= '0;
                                row_q <= row_q + DIM_ONE;
                            end else begin
                                col_q <= col_q + DIM_ONE;
                            end
                        end else begin
                            grp_q <= grp_q + GRP_ONE;
                        end
                        // last must coincide with the counted end of image
                        if (pixel_in_last != is_final)
                            err_last <= 1'b1;
                        if (pixel_in_last || is_final)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!mac_valid || mac_ready) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONV1X1_PERF_CNT_EN
    // Saturating stall and decimation counters, cleared at each start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles  <= '0;
            perf_dropped_words <= '0;
        end else if (state == S_IDLE) begin
            if (go) begin
                perf_stall_cycles  <= '0;
                perf_dropped_words <= '0;
            end
        end else begin
            if ((state == S_RUN || state == S_DRAIN) && mac_valid && !mac_ready &&
                perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (xfer && drop_cur && perf_dropped_words != '1)
                perf_dropped_words <= perf_dropped_words + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv1x1_stream_sequencer.sv
// Randomized bench for conv1x1_stream_sequencer. The reference derives each
// word's (group, column, row) from its index in the stream by division and
// modulo, predicts the output register, handshakes and done timing, and is
// compared against the DUT on every falling edge.
module tb_conv1x1_stream_sequencer;
    localparam int LANES = 8;
    localparam int WA    = 12;
    localparam int GW    = 10;
    localparam int DW    = 16;
    localparam int PW    = 8 * LANES;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic [GW-1:0] cfg_ci_groups = '0;
    logic [DW-1:0] cfg_img_width = '0;
    logic [DW-1:0] cfg_img_height = '0;
    logic          cfg_stride_2 = 1'b0;
    logic [WA-1:0] cfg_wt_base_addr = '0;
    logic [PW-1:0] pixel_in = '0;
    logic          pixel_in_valid = 1'b0;
    logic          pixel_in_last = 1'b0;
    logic          pixel_in_ready;
    logic [PW-1:0] mac_pixel;
    logic [WA-1:0] mac_wt_addr;
    logic          mac_first_channel, mac_last_channel, mac_valid;
    logic          mac_ready = 1'b1;
    logic          busy, done, err_last;
`ifdef CONV1X1_PERF_CNT_EN
    logic [31:0]   perf_stall_cycles, perf_dropped_words;
`endif

    conv1x1_stream_sequencer #(.LANES(LANES), .WT_ADDR_WIDTH(WA), .GRP_W(GW), .DIM_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .go(go),
        .cfg_ci_groups(cfg_ci_groups), .cfg_img_width(cfg_img_width),
        .cfg_img_height(cfg_img_height), .cfg_stride_2(cfg_stride_2),
        .cfg_wt_base_addr(cfg_wt_base_addr),
        .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid), .pixel_in_last(pixel_in_last),
        .pixel_in_ready(pixel_in_ready),
        .mac_pixel(mac_pixel), .mac_wt_addr(mac_wt_addr),
        .mac_first_channel(mac_first_channel), .mac_last_channel(mac_last_channel),
        .mac_valid(mac_valid), .mac_ready(mac_ready),
`ifdef CONV1X1_PERF_CNT_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_dropped_words(perf_dropped_words),
`endif
        .busy(busy), .done(done), .err_last(err_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 accepting, 2 draining, 3 done-pulse
    int          m_phase = 0;
    int          m_k = 0;
    int          m_g = 1, m_w = 1, m_h = 1;
    bit          m_s2 = 0;
    int          m_base = 0;
    bit          m_err = 0;
    bit          m_ov = 0;
    logic [63:0] m_pix = '0;
    logic [WA-1:0] m_addr = '0;
    bit          m_first = 0, m_lastc = 0;
    int          m_stall = 0, m_drop = 0;
    int          beats = 0, xfers = 0, cyc = 0;
    int          final_xfer_cyc = 0, dut_done_cyc = 0;
    int          rmode = 0;

    function automatic bit drop_of(input int k);
        int col, row;
        col = (k / m_g) % m_w;
        row = k / (m_g * m_w);
        return m_s2 && ((col % 2) == 1 || (row % 2) == 1);
    endfunction

    // Compare DUT against the model, then advance the model over the next edge.
    always @(negedge clk) begin
        bit exp_ready, xf, fin, dr;
        int g;
        cyc++;
        if (done) dut_done_cyc = cyc;
        if (!rst_n) begin
            chk("rst_ready", {63'd0, pixel_in_ready}, 64'd0);
            chk("rst_valid", {63'd0, mac_valid}, 64'd0);
            chk("rst_pixel", mac_pixel, 64'd0);
            chk("rst_addr", {52'd0, mac_wt_addr}, 64'd0);
            chk("rst_flags", {62'd0, mac_first_channel, mac_last_channel}, 64'd0);
            chk("rst_status", {61'd0, busy, done, err_last}, 64'd0);
            m_phase = 0; m_ov = 0; m_err = 0;
        end else begin
            exp_ready = (m_phase == 1) && (drop_of(m_k) || !m_ov || mac_ready);
            chk("in_ready", {63'd0, pixel_in_ready}, {63'd0, exp_ready});
            chk("mac_valid", {63'd0, mac_valid}, {63'd0, m_ov});
            chk("busy", {63'd0, busy}, {63'd0, m_phase != 0});
            chk("done", {63'd0, done}, {63'd0, m_phase == 3});
            chk("err_last", {63'd0, err_last}, {63'd0, m_err});
            if (m_ov) begin
                chk("mac_pixel", mac_pixel, m_pix);
                chk("mac_wt_addr", {52'd0, mac_wt_addr}, {52'd0, m_addr});
                chk("first_ch", {63'd0, mac_first_channel}, {63'd0, m_first});
                chk("last_ch", {63'd0, mac_last_channel}, {63'd0, m_lastc});
            end
            if (m_ov && mac_ready) beats++;
            if ((m_phase == 1 || m_phase == 2) && m_ov && !mac_ready) m_stall++;
            case (m_phase)
                0: if (go) begin
                    m_g = int'(cfg_ci_groups); m_w = int'(cfg_img_width);
                    m_h = int'(cfg_img_height); m_s2 = cfg_stride_2;
                    m_base = int'(cfg_wt_base_addr);
                    m_k = 0; m_err = 0; m_stall = 0; m_drop = 0; m_phase = 1;
                end
                1: begin
                    xf = pixel_in_valid && exp_ready;
                    if (xf) begin
                        fin = (m_k == m_g * m_w * m_h - 1);
                        if (pixel_in_last != fin) m_err = 1;
                        dr = drop_of(m_k);
                        g = m_k % m_g;
                        if (!dr) begin
                            m_ov = 1; m_pix = pixel_in;
                            m_addr = WA'(m_base + g);
                            m_first = (g == 0); m_lastc = (g == m_g - 1);
                        end else begin
                            m_drop++;
                            if (mac_ready) m_ov = 0;
                        end
                        m_k++; xfers++;
                        if (fin || pixel_in_last) begin
                            m_phase = 2; final_xfer_cyc = cyc;
                        end
                    end else if (mac_ready) m_ov = 0;
                end
                2: if (!m_ov || mac_ready) begin m_ov = 0; m_phase = 3; end
                default: m_phase = 0;
            endcase
        end
    end

    // Output backpressure pattern: 0 always ready, 1 toggle, 2 random.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: mac_ready = 1'b1;
            1: mac_ready = ~mac_ready;
            default: mac_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Configure, pulse go, and stream one image; optionally abort with reset.
    task automatic run_img(input int g, input int w, input int h, input bit s2,
                           input int base, input int last_at, input int rm,
                           input bit vgaps, input int abort_at, input bit mid_go);
        int  idx, budget, cur;
        bit  xf, seen;
        rmode = rm;
        cfg_ci_groups = GW'(g); cfg_img_width = DW'(w); cfg_img_height = DW'(h);
        cfg_stride_2 = s2; cfg_wt_base_addr = WA'(base);
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        beats = 0; xfers = 0;
        idx = 0; cur = -1; budget = 4000;
        while (idx < g * w * h && budget > 0) begin
            go = 1'b0;
            if (idx != cur) begin
                pixel_in = {$urandom, $urandom};
                cur = idx;
            end
            pixel_in_last  = (idx == last_at);
            pixel_in_valid = vgaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (idx == abort_at) begin
                rst_n = 1'b0; pixel_in_valid = 1'b0;
                @(posedge clk); #1; @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            if (mid_go && idx == 5) begin
                go = 1'b1;
                cfg_ci_groups = GW'($urandom_range(1, 7));
                cfg_wt_base_addr = WA'($urandom);
                cfg_stride_2 = ~s2;
            end
            @(negedge clk); xf = pixel_in_valid && pixel_in_ready;
            @(posedge clk); #1;
            budget--;
            if (xf) begin
                idx++;
                if (last_at >= 0 && idx > last_at) break;
            end
        end
        pixel_in_valid = 1'b0; pixel_in_last = 1'b0; go = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=none required=done pulse");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 4x4, 2 groups, stride 1, always ready
        run_img(2, 4, 4, 0, 0, 31, 0, 0, -1, 0);
        chk("t1_beats", 64'(beats), 64'd32);
        chk("t1_xfers", 64'(xfers), 64'd32);
        chk("t1_done_lat", 64'(dut_done_cyc - final_xfer_cyc), 64'd2);
        chk("t1_err", {63'd0, err_last}, 64'd0);

        // same image, stride 2
        run_img(2, 4, 4, 1, 0, 31, 0, 0, -1, 0);
        chk("t2_beats", 64'(beats), 64'd8);
        chk("t2_xfers", 64'(xfers), 64'd32);
        chk("t2_model_drop", 64'(m_drop), 64'd24);
`ifdef CONV1X1_PERF_CNT_EN
        chk("t2_perf_drop", 64'(perf_dropped_words), 64'd24);
`endif

        // base 100, 3 groups, 2x2, toggling ready
        run_img(3, 2, 2, 0, 100, 11, 1, 0, -1, 0);
        chk("t3_beats", 64'(beats), 64'd12);
`ifdef CONV1X1_PERF_CNT_EN
        chk("t3_perf_stall", 64'(perf_stall_cycles), 64'(m_stall));
`endif

        // last asserted early on word 10 (index 9)
        run_img(2, 4, 4, 0, 0, 9, 0, 0, -1, 0);
        chk("t4_err", {63'd0, err_last}, 64'd1);
        chk("t4_xfers", 64'(xfers), 64'd10);

        // last never asserted
        run_img(2, 4, 4, 0, 0, -1, 0, 0, -1, 0);
        chk("t5_err", {63'd0, err_last}, 64'd1);
        chk("t5_xfers", 64'(xfers), 64'd32);

        // reset at word 15, then an odd-sized stride-2 image
        run_img(2, 4, 4, 0, 0, 31, 0, 0, 15, 0);
        chk("t6_abort_busy", {63'd0, busy}, 64'd0);
        run_img(3, 3, 2, 1, 4090, 17, 2, 1, -1, 0);
        chk("t6_beats", 64'(beats), 64'd6);
        chk("t6_err", {63'd0, err_last}, 64'd0);

        // go and config changes while busy are ignored
        run_img(2, 4, 4, 0, 5, 31, 2, 1, -1, 1);
        chk("t7_beats", 64'(beats), 64'd32);

        // random configurations and handshakes
        for (int r = 0; r < 12; r++) begin
            int g, w, h, n;
            bit s2;
            g = $urandom_range(1, 4); w = $urandom_range(1, 5); h = $urandom_range(1, 5);
            s2 = 1'($urandom_range(0, 1));
            n = g * w * h;
            run_img(g, w, h, s2, $urandom_range(0, 4095), n - 1, 2, 1, -1, 0);
            chk("rnd_beats", 64'(beats),
                64'(s2 ? g * ((w + 1) / 2) * ((h + 1) / 2) : n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
